uart_rx: RTL and testbench

- Serial receiver for the 8N1 UART link: recovers bytes from the asynchronous Rx line and delivers each byte with a one-cycle valid strobe.
- Receive-side counterpart of the team's UART transmitter; same parameterisation (clock frequency / baud rate), same frame format (1 start, 8 data LSB first, 1 stop).
- Sits between the board pin and the byte-level consumer (command parser / FIFO).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// bit-period helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int calc_clks_per_bit(input int clks_freq, input int baud_rate);
        return clks_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous input; both stages reset
// to RESET_VAL so an idle-high line reads idle straight out of reset.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make each stage capture the other's old
    // value, so this really is two flops in series rather than one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised line, one-cycle
// flag_rx on a good frame and Frame_Err on a low stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_FREQ = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic [7:0] RX_Byte,
    output logic       flag_rx,
    output logic       Frame_Err,
    output logic       Busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLKS_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           byte_q, byte_d;
    logic                 flag_q, flag_d;
    logic                 err_q, err_d;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (Rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        flag_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;  // high here means a glitch, not a start bit
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        flag_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK_WAIT: begin
                // Hold off until the line is released so a break is one error, not many frames.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign RX_Byte   = byte_q;
    assign flag_rx   = flag_q;
    assign Frame_Err = err_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: nominal, back-to-back,
// glitch, framing error/break, mid-frame reset and baud-offset frames.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_byte;
    logic       flag_rx;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int flag_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int busy_cnt = 0;
    int flag_cyc = 0;
    logic [7:0] rx_bytes[$];

    uart_rx #(.CLKS_FREQ(1600), .BAUD_RATE(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .Rx        (rx),
        .RX_Byte   (rx_byte),
        .flag_rx   (flag_rx),
        .Frame_Err (frame_err),
        .Busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (flag_rx) begin
                flag_cnt = flag_cnt + 1;
                flag_cyc = cyc;
                rx_bytes.push_back(rx_byte);
            end
            if (frame_err) err_cnt = err_cnt + 1;
            if (flag_rx && frame_err) both_cnt = both_cnt + 1;
            if (busy) busy_cnt = busy_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_cycles(n);
    endtask

    // stretch=1 alternates 16/17-cycle bits: mean period 16.5, about +3%.
    function automatic int bit_len(input int k, input bit stretch);
        return (stretch && (k % 2 == 1)) ? 17 : 16;
    endfunction

    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input bit stretch, output int t_start);
        t_start = cyc;
        drive_bit(1'b0, bit_len(0, stretch));
        for (int i = 0; i < 8; i++) drive_bit(data[i], bit_len(i + 1, stretch));
        drive_bit(stop_val, bit_len(9, stretch));
    endtask

    initial begin
        int t0;
        int t_dummy;
        int lat;
        int f0, e0, b0, bw;
        logic [7:0] last_byte;

        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(3);
        @(negedge clk);
        check("reset_rx_byte", {24'd0, rx_byte}, 32'h00);
        check("reset_flag", {31'd0, flag_rx}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(5);

        // Single nominal frame 0xA5.
        f0 = flag_cnt; e0 = err_cnt; b0 = busy_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        wait_cycles(30);
        lat = flag_cyc - t0;
        bw  = busy_cnt - b0;
        check("a5_flag_count", flag_cnt - f0, 1);
        check("a5_rx_byte", {24'd0, rx_byte}, 32'hA5);
        check("a5_latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
        check("a5_busy_cycles", (bw >= 151 && bw <= 153) ? 152 : bw, 152);
        check("a5_no_frame_err", err_cnt - e0, 0);

        // Back-to-back 0x00 then 0xFF with no idle time.
        f0 = flag_cnt;
        send_frame(8'h00, 1'b1, 1'b0, t_dummy);
        send_frame(8'hFF, 1'b1, 1'b0, t_dummy);
        wait_cycles(30);
        check("b2b_flag_count", flag_cnt - f0, 2);
        if (flag_cnt - f0 == 2) begin
            check("b2b_first_byte", {24'd0, rx_bytes[rx_bytes.size() - 2]}, 32'h00);
            check("b2b_second_byte", {24'd0, rx_bytes[rx_bytes.size() - 1]}, 32'hFF);
        end
        check("b2b_rx_byte", {24'd0, rx_byte}, 32'hFF);

        // Three-cycle low glitch must be rejected at the start-bit check.
        f0 = flag_cnt; e0 = err_cnt; b0 = busy_cnt;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 40);
        bw = busy_cnt - b0;
        check("glitch_busy_short", (bw > 0 && bw < 12) ? 1 : 0, 1);
        check("glitch_no_flag", flag_cnt - f0, 0);
        check("glitch_no_err", err_cnt - e0, 0);
        check("glitch_rx_byte", {24'd0, rx_byte}, 32'hFF);

        // 0x3C with a low stop bit, line then held low (break).
        f0 = flag_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, t_dummy);
        drive_bit(1'b0, 100);
        @(negedge clk);
        check("break_busy_held", {31'd0, busy}, 32'd1);
        check("break_err_count", err_cnt - e0, 1);
        @(posedge clk);
        #1;
        drive_bit(1'b1, 6);
        @(negedge clk);
        check("break_busy_released", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        wait_cycles(200);
        check("break_single_err", err_cnt - e0, 1);
        check("break_no_flag", flag_cnt - f0, 0);
        check("break_rx_byte_kept", {24'd0, rx_byte}, 32'hFF);

        // Reset during data bit 4 of 0x5A, then receive 0x81.
        last_byte = 8'h5A;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(last_byte[i], 16);
        drive_bit(last_byte[4], 8);
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(3);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rx_byte", {24'd0, rx_byte}, 32'h00);
        check("midrst_flag", {31'd0, flag_rx}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(20);
        f0 = flag_cnt;
        send_frame(8'h81, 1'b1, 1'b0, t_dummy);
        wait_cycles(30);
        check("midrst_flag_count", flag_cnt - f0, 1);
        check("midrst_rx_byte_81", {24'd0, rx_byte}, 32'h81);

        // 0xC3 with bit period about 3% long.
        f0 = flag_cnt; e0 = err_cnt;
        send_frame(8'hC3, 1'b1, 1'b1, t_dummy);
        wait_cycles(30);
        check("slow_flag_count", flag_cnt - f0, 1);
        check("slow_rx_byte", {24'd0, rx_byte}, 32'hC3);
        check("slow_no_err", err_cnt - e0, 0);

        check("flag_err_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
